// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO with watermarks, fill level, flush and sticky error flags.
module fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic                         full,
  output logic                         almost_full,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         empty,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         flush,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [LW-1:0] MAX = LW'(DEPTH);
  localparam logic [LW-1:0] AF = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE = LW'(AE_LEVEL);
  if (DATA_WIDTH < 1 || DEPTH < 1 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_params
    $error("fifo_flagged: illegal parameter values");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign full = level == MAX;
  assign empty = level == '0;
  assign almost_full = level >= AF;
  assign almost_empty = level <= AE;
  assign data_out = empty ? '0 : mem[rd_ptr];
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;
  // Pointers wrap by explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level <= '0;
      end else begin
        if (wr_acc) begin
          mem[wr_ptr] <= data_in;
          wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
        end
        if (rd_acc) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        if (wr_acc != rd_acc) level <= wr_acc ? level + 1'b1 : level - 1'b1;
      end
      overflow <= (wr_en && full && !flush) || (overflow && !err_clr);
      underflow <= (rd_en && empty && !flush) || (underflow && !err_clr);
    end
endmodule

// File: tb/tb_fifo_flagged.sv
// tb_fifo_flagged: directed self-checking bench for fifo_flagged (DEPTH=16 and DEPTH=5 instances).
module tb_fifo_flagged;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wr_en = 0, rd_en = 0, flush = 0, err_clr = 0;
  logic [7:0] data_in = '0, data_out;
  logic full, almost_full, empty, almost_empty, overflow, underflow;
  logic [4:0] level;
  logic w5 = 0, r5 = 0;
  logic [7:0] d5 = '0, data_out5;
  logic full5, af5, empty5, ae5, ovf5, unf5;
  logic [2:0] level5;
  int checks = 0, failures = 0;

  fifo_flagged u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .data_out(data_out), .empty(empty),
    .almost_empty(almost_empty), .level(level), .flush(flush), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr));

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .wr_en(w5), .data_in(d5), .full(full5),
    .almost_full(af5), .rd_en(r5), .data_out(data_out5), .empty(empty5),
    .almost_empty(ae5), .level(level5), .flush(1'b0), .overflow(ovf5),
    .underflow(unf5), .err_clr(1'b0));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin failures++; $display("FAIL reset_flags got %b exp 1010", {empty, full, almost_empty, almost_full}); end
    checks++; if (level !== 5'd0 || data_out !== 8'h00) begin failures++; $display("FAIL reset_level_data got %0d/%h exp 0/00", level, data_out); end
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_errs got %b exp 00", {overflow, underflow}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1; data_in = 8'(i);
      tick;
      checks++; if (level !== 5'(i)) begin failures++; $display("FAIL fill_level got %0d exp %0d", level, i); end
      checks++; if (almost_empty !== (i <= 2) || almost_full !== (i >= 14) || full !== (i == 16)) begin failures++; $display("FAIL fill_flags at %0d got ae=%b af=%b f=%b", i, almost_empty, almost_full, full); end
      checks++; if (data_out !== 8'h01) begin failures++; $display("FAIL fill_head got %h exp 01", data_out); end
    end
    wr_en = 0;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (data_out !== 8'(i)) begin failures++; $display("FAIL drain_data got %h exp %h", data_out, 8'(i)); end
      rd_en = 1;
      tick;
      checks++; if (level !== 5'(16 - i)) begin failures++; $display("FAIL drain_level got %0d exp %0d", level, 16 - i); end
    end
    rd_en = 0;
    checks++; if (empty !== 1'b1 || data_out !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL drain_end got e=%b d=%h o=%b u=%b", empty, data_out, overflow, underflow); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 3; i++) begin w5 = 1; d5 = 8'h11 + 8'(i); tick; end
    w5 = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_out5 !== 8'h11 + 8'(i)) begin failures++; $display("FAIL wrap_pre got %h exp %h", data_out5, 8'h11 + 8'(i)); end
      r5 = 1; tick;
    end
    r5 = 0;
    for (int i = 0; i < 5; i++) begin w5 = 1; d5 = 8'h21 + 8'(i); tick; end
    w5 = 0;
    checks++; if (full5 !== 1'b1 || level5 !== 3'd5 || af5 !== 1'b1) begin failures++; $display("FAIL wrap_full got f=%b l=%0d af=%b exp 1/5/1", full5, level5, af5); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (data_out5 !== 8'h21 + 8'(i)) begin failures++; $display("FAIL wrap_data got %h exp %h", data_out5, 8'h21 + 8'(i)); end
      r5 = 1; tick;
    end
    r5 = 0;
    checks++; if (empty5 !== 1'b1 || data_out5 !== 8'h00) begin failures++; $display("FAIL wrap_empty got e=%b d=%h", empty5, data_out5); end
  endtask

  task automatic test_simultaneous;
    logic [7:0] exp_q[$];
    for (int i = 0; i < 8; i++) begin wr_en = 1; data_in = 8'h31 + 8'(i); tick; end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1; data_in = 8'h41 + 8'(i);
      checks++; if (data_out !== 8'h31 + 8'(i)) begin failures++; $display("FAIL both_head got %h exp %h", data_out, 8'h31 + 8'(i)); end
      tick;
      checks++; if (level !== 5'd8) begin failures++; $display("FAIL both_level got %0d exp 8", level); end
    end
    rd_en = 0;
    for (int i = 0; i < 8; i++) begin data_in = 8'h51 + 8'(i); tick; end
    checks++; if (full !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL both_fill got f=%b l=%0d", full, level); end
    rd_en = 1; data_in = 8'h99;
    tick;
    wr_en = 0; rd_en = 0;
    checks++; if (level !== 5'd15 || overflow !== 1'b1 || full !== 1'b0 || data_out !== 8'h36) begin failures++; $display("FAIL both_at_full got l=%0d o=%b f=%b d=%h exp 15/1/0/36", level, overflow, full, data_out); end
    err_clr = 1; tick; err_clr = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL err_clr_ovf got %b exp 0", overflow); end
    exp_q = {8'h36, 8'h37, 8'h38, 8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58};
    foreach (exp_q[i]) begin
      checks++; if (data_out !== exp_q[i]) begin failures++; $display("FAIL both_order got %h exp %h", data_out, exp_q[i]); end
      rd_en = 1; tick;
    end
    rd_en = 0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL both_drained got %b exp 1", empty); end
    wr_en = 1; rd_en = 1; data_in = 8'h77;
    tick;
    wr_en = 0; rd_en = 0;
    checks++; if (level !== 5'd1 || underflow !== 1'b1 || data_out !== 8'h77) begin failures++; $display("FAIL both_at_empty got l=%0d u=%b d=%h exp 1/1/77", level, underflow, data_out); end
    rd_en = 1; tick; rd_en = 0;
    checks++; if (level !== 5'd0 || underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got l=%0d u=%b exp 0/1", level, underflow); end
    err_clr = 1; tick; err_clr = 0;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL err_clr_unf got %b exp 0", underflow); end
  endtask

  task automatic test_err_collide;
    for (int i = 0; i < 16; i++) begin wr_en = 1; data_in = 8'h60 + 8'(i); tick; end
    err_clr = 1; data_in = 8'hEE;
    tick;
    wr_en = 0;
    checks++; if (overflow !== 1'b1 || level !== 5'd16) begin failures++; $display("FAIL set_wins got o=%b l=%0d exp 1/16", overflow, level); end
    tick;
    err_clr = 0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_after got %b exp 0", overflow); end
    wr_en = 1; tick; wr_en = 0;
    for (int i = 0; i < 7; i++) begin rd_en = 1; tick; end
    rd_en = 0;
    checks++; if (level !== 5'd9 || data_out !== 8'h67 || overflow !== 1'b1) begin failures++; $display("FAIL pre_flush got l=%0d d=%h o=%b exp 9/67/1", level, data_out, overflow); end
  endtask

  task automatic test_flush;
    flush = 1; wr_en = 1; rd_en = 1; data_in = 8'h55;
    tick;
    flush = 0; wr_en = 0; rd_en = 0;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00) begin failures++; $display("FAIL flush got l=%0d e=%b d=%h exp 0/1/00", level, empty, data_out); end
    checks++; if (overflow !== 1'b1 || underflow !== 1'b0) begin failures++; $display("FAIL flush_errs got o=%b u=%b exp 1/0", overflow, underflow); end
    wr_en = 1; data_in = 8'hAB; err_clr = 1;
    tick;
    wr_en = 0; err_clr = 0;
    checks++; if (data_out !== 8'hAB || level !== 5'd1 || overflow !== 1'b0) begin failures++; $display("FAIL post_flush got d=%h l=%0d o=%b exp AB/1/0", data_out, level, overflow); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 16; i++) begin wr_en = 1; data_in = 8'hB0 + 8'(i); tick; end
    wr_en = 0;
    for (int i = 0; i < 9; i++) begin rd_en = 1; tick; end
    rd_en = 0;
    checks++; if (level !== 5'd7 || overflow !== 1'b1) begin failures++; $display("FAIL pre_reset got l=%0d o=%b exp 7/1", level, overflow); end
    #2 rst_n = 0;
    #1;
    checks++; if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL async_reset got l=%0d e=%b o=%b d=%h exp 0/1/0/00", level, empty, overflow, data_out); end
    #1 rst_n = 1;
    tick;
    wr_en = 1; data_in = 8'hC1; tick;
    data_in = 8'hC2; tick;
    wr_en = 0;
    checks++; if (data_out !== 8'hC1 || level !== 5'd2) begin failures++; $display("FAIL resume got d=%h l=%0d exp C1/2", data_out, level); end
    rd_en = 1; tick; rd_en = 0;
    checks++; if (data_out !== 8'hC2 || level !== 5'd1) begin failures++; $display("FAIL resume_rd got d=%h l=%0d exp C2/1", data_out, level); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_wrap;
    test_simultaneous;
    test_err_collide;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
